regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port among NUM_REQ writeback requesters, e.g. ALU result and load data.
- Arbitration is round-robin.
- Output is a registered write command that drives writeRegister/writeData/regWrite of register_file.
- Also provides an x0-write filter, a writeback stall, and a hazard-hit query for the decode stage.

Parameters:
NUM_REQ, 2, number of requesters (legal 2..4)
DATA_W, 64, write data width
ADDR_W, 5, register address width

Ports:
clk  in  1  single clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset, sampled on clk rising edge
req_valid  in  NUM_REQ  per-requester write request
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
req_addr  in  NUM_REQ*ADDR_W  requester i's address at [i*ADDR_W +: ADDR_W]
req_data  in  NUM_REQ*DATA_W  requester i's data at [i*DATA_W +: DATA_W]
wb_stall  in  1  blocks new grants this cycle
write_register  out  ADDR_W  to register_file writeRegister
write_data  out  DATA_W  to register_file writeData
reg_write  out  1  to register_file regWrite
hz_addr  in  ADDR_W  decode-stage source address query
hz_hit  out  1  a write to hz_addr is being presented this cycle

Behaviour:
- Reset (rst_n=0 at edge): reg_write=0, write_register=0, write_data=0, rr_ptr=0. req_ready=0 while rst_n=0.
- Grant (combinational):
  - If wb_stall=1, no grant; req_ready=0.
  - Otherwise grant the first i with req_valid[i]=1, scanning from rr_ptr upward with wrap modulo NUM_REQ.
  - req_ready[i]=1 only for the granted i. req_ready may depend combinationally on req_valid.
- Handshake: a transfer occurs when req_valid[i] && req_ready[i]. Requesters hold valid/addr/data stable until accepted.
- Output register, updated each edge:
  - Transfer with addr!=0: write_register<=addr, write_data<=data, reg_write<=1.
  - Transfer with addr==0: accepted and dropped; reg_write<=0; write_register/write_data hold.
  - No transfer (idle or stalled): reg_write<=0; write_register/write_data hold.
- Latency: exactly 1 cycle from accept edge to reg_write=1. At most one write per cycle. reg_write is never high two cycles for one transfer.
- rr_ptr: on any transfer (including x0 drops) rr_ptr<=(granted+1) mod NUM_REQ. Unchanged otherwise.
- Fairness: with all requesters continuously valid and no stall, each requester is granted exactly once per NUM_REQ cycles.
- Stall: wb_stall=1 blocks only new grants. A write already in the output register still presents for its one cycle.
- hz_hit = reg_write && (write_register==hz_addr) && (hz_addr!=0). Purely combinational; no registered path.
- Reset mid-operation:
  - A pending presented write is cancelled (reg_write=0 next cycle).
  - Un-accepted requests are not remembered; requesters are reset by the same rst_n.
- Simultaneous valid on all requesters with rr_ptr pointing at an invalid one: the next valid index in wrap order wins.

Optional Feature:
- Macro: WB_ARB_STATS_EN.
- Defined:
  - Adds output grant_cnt (NUM_REQ*16): per-requester saturating 16-bit counters of transfers, including x0 drops.
  - Adds output conflict_cnt (16): saturates at 16'hFFFF; increments each cycle ≥2 requesters are valid and none stalled.
  - All counters clear on reset.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset: rst_n=0 two cycles with req_valid=2'b11 -> req_ready=0, reg_write=0, write_register=0, write_data=0. After release, first grant goes to req 0.
- Single write: req0 addr=5, data=64'hDEAD_BEEF_0000_0001 accepted at edge N -> at N+1 reg_write=1, write_register=5, write_data matches. At N+2 reg_write=0.
- Round-robin: both valid continuously for 4 cycles (req0 addr=1, req1 addr=2) -> grant order 0,1,0,1; write_register sequence 1,2,1,2 on consecutive cycles.
- x0 filter: req1 addr=0, data=64'h1234 -> req_ready[1]=1, reg_write stays 0, write_register/write_data unchanged, rr_ptr advances to 0.
- Stall: wb_stall=1 for 3 cycles with req0 valid (addr=7) -> req_ready=0 for 3 cycles; accepted first cycle after stall drops; reg_write=1, write_register=7 the cycle after that.
- Hazard: reg_write=1, write_register=9 -> hz_hit=1 for hz_addr=9, 0 for hz_addr=8; write to x0 never sets hz_hit with hz_addr=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among writeback sources.
// Define WB_ARB_STATS_EN to add per-requester grant counters and a conflict counter.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      wb_stall,
    output logic [ADDR_W-1:0]         write_register,
    output logic [DATA_W-1:0]         write_data,
    output logic                      reg_write,
    input  logic [ADDR_W-1:0]         hz_addr,
    output logic                      hz_hit
`ifdef WB_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]     grant_cnt,
    output logic [15:0]               conflict_cnt
`endif
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]  rrPtr;
    logic [PTR_W-1:0]  grantIdx;
    logic              grantValid;
    logic [ADDR_W-1:0] grantAddr;
    logic [DATA_W-1:0] grantData;

    // Scan from rrPtr upward with wrap; the first valid requester wins.
    always_comb begin
        int idx;
        idx        = 0;
        grantValid = 1'b0;
        grantIdx   = '0;
        if (rst_n && !wb_stall) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (int'(rrPtr) + k) % NUM_REQ;
                if (!grantValid && req_valid[idx]) begin
                    grantValid = 1'b1;
                    grantIdx   = PTR_W'(idx);
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grantValid) req_ready[grantIdx] = 1'b1;
    end

    assign grantAddr = req_addr[int'(grantIdx)*ADDR_W +: ADDR_W];
    assign grantData = req_data[int'(grantIdx)*DATA_W +: DATA_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rrPtr          <= '0;
            reg_write      <= 1'b0;
            write_register <= '0;
            write_data     <= '0;
        end else begin
            reg_write <= 1'b0;
            if (grantValid) begin
                rrPtr <= (grantIdx == PTR_W'(NUM_REQ - 1)) ? '0 : grantIdx + 1'b1;
                // Writes to x0 are accepted but never reach the register file.
                if (grantAddr != '0) begin
                    write_register <= grantAddr;
                    write_data     <= grantData;
                    reg_write      <= 1'b1;
                end
            end
        end
    end

    assign hz_hit = reg_write && (write_register == hz_addr) && (hz_addr != '0);

`ifdef WB_ARB_STATS_EN
    int validCnt;

    always_comb begin
        validCnt = 0;
        for (int i = 0; i < NUM_REQ; i++) validCnt += int'(req_valid[i]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_cnt    <= '0;
            conflict_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grantValid && (int'(grantIdx) == i) && (grant_cnt[i*16 +: 16] != 16'hFFFF))
                    grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
            end
            if (!wb_stall && (validCnt >= 2) && (conflict_cnt != 16'hFFFF))
                conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`endif

endmodule
